// File: rtl/irda_pkg.sv
// Shared IrDA SIR definitions: frame layout, receiver FSM states and the parity
// function also used by the transmitter's parity generator.
package irda_pkg;

  localparam int unsigned FRAME_BITS = 10;  // start, 7 data, parity, stop
  localparam int unsigned DATA_BITS  = 7;
  localparam int unsigned PARITY_IDX = 8;
  localparam int unsigned STOP_IDX   = 9;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDone
  } irda_state_e;

  // Parity bit for a data word: even parity gives ^data, odd parity gives ~^data.
  function automatic logic irda_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/irda_rx_pulse_detector.sv
// IrDA receive pulse front end: 2-FF synchroniser on the raw IR input, optional
// glitch filter, and a rising-edge flag on the resulting pulse level.
//
// Configuration macro: IRDA_RX_GLITCH_FILTER_EN
//   defined   : pulse_det_o rises only after MIN_PULSE consecutive high samples and
//               falls on the first low sample.
//   undefined : pulse_det_o is the synchroniser output.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   rxd_ir_i     asynchronous IR input
//   pulse_det_o  synchronised (optionally filtered) pulse level
//   rise_o       high for one cycle when pulse_det_o goes 0 -> 1
module irda_rx_pulse_detector
  import irda_pkg::*;
`ifdef IRDA_RX_GLITCH_FILTER_EN
#(
  parameter int unsigned MIN_PULSE = 4
)
`endif
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_ir_i,
  output logic pulse_det_o,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       det_prev_q;
  logic       pulse_det;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      det_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rxd_ir_i};
      det_prev_q <= pulse_det;
    end
  end

`ifdef IRDA_RX_GLITCH_FILTER_EN
  localparam int unsigned CntW = $clog2(MIN_PULSE + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MIN_PULSE - 1);

  // Counts consecutive high samples, saturating; the MIN_PULSE-th high sample
  // itself raises pulse_det (count already at MIN_PULSE-1 when it arrives).
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (sync_q[1]) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse_det = sync_q[1] & (cnt_q == CntMax);
`else
  assign pulse_det = sync_q[1];
`endif

  assign pulse_det_o = pulse_det;
  assign rise_o      = pulse_det & ~det_prev_q;

endmodule

// File: rtl/irda_receiver.sv
// IrDA SIR receiver: recovers 10-bit frames (start 0, data[6:0] LSB first, parity,
// stop 1) from the IR pulse stream. A high pulse inside a bit window means 0, no
// pulse means 1. Each frame ends with a one-cycle valid strobe.
//
// Configuration macro: IRDA_RX_GLITCH_FILTER_EN (enables MIN_PULSE glitch filter).
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   ena         receiver enable; low forces idle
//   rxd_ir      asynchronous IR input
//   data_rxd    last received data word
//   valid       one-cycle strobe when data_rxd/parity_err/frame_err update
//   parity_err  parity mismatch on last frame
//   frame_err   stop window contained a pulse on last frame
//   busy        frame reception in progress
module irda_receiver
  import irda_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          PARITY_ODD   = 1'b0
`ifdef IRDA_RX_GLITCH_FILTER_EN
  ,
  parameter int unsigned MIN_PULSE    = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 rxd_ir,
  output logic [DATA_BITS-1:0] data_rxd,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);

  logic pulse_det, pulse_rise;

  irda_rx_pulse_detector
`ifdef IRDA_RX_GLITCH_FILTER_EN
  #(
    .MIN_PULSE(MIN_PULSE)
  )
`endif
  u_pulse_det (
    .clk_i       (clk),
    .rst_i       (rst),
    .rxd_ir_i    (rxd_ir),
    .pulse_det_o (pulse_det),
    .rise_o      (pulse_rise)
  );

  irda_state_e           state_q, state_d;
  logic [BaudW-1:0]      baud_q, baud_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic                  pulse_seen_q, pulse_seen_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  valid_q, valid_d;
  logic                  seen_now;

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_idx_d    = bit_idx_q;
    pulse_seen_d = pulse_seen_q;
    shift_d      = shift_q;
    data_d       = data_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    valid_d      = 1'b0;
    // Sticky OR over the window, including the current sample.
    seen_now     = pulse_seen_q | pulse_det;

    unique case (state_q)
      StIdle: begin
        baud_d       = '0;
        bit_idx_d    = '0;
        pulse_seen_d = 1'b0;
        if (ena && pulse_rise) begin
          // The start pulse opens the start window and is already counted in it.
          state_d      = StRecv;
          baud_d       = BaudW'(1);
          pulse_seen_d = 1'b1;
        end
      end
      StRecv: begin
        if (!ena) begin
          state_d      = StIdle;
          baud_d       = '0;
          bit_idx_d    = '0;
          pulse_seen_d = 1'b0;
        end else if (baud_q == BaudMax) begin
          shift_d      = {~seen_now, shift_q[FRAME_BITS-1:1]};
          baud_d       = '0;
          pulse_seen_d = 1'b0;
          bit_idx_d    = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'(STOP_IDX)) begin
            state_d = StDone;
          end
        end else begin
          baud_d       = baud_q + 1'b1;
          pulse_seen_d = seen_now;
        end
      end
      StDone: begin
        // Start bit in shift_q[0] is not checked: its pulse defined the window.
        data_d    = shift_q[PARITY_IDX-1:1];
        perr_d    = shift_q[PARITY_IDX] != irda_parity(shift_q[PARITY_IDX-1:1], PARITY_ODD);
        ferr_d    = ~shift_q[STOP_IDX];
        valid_d   = 1'b1;
        bit_idx_d = '0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      pulse_seen_q <= 1'b0;
      shift_q      <= '0;
      data_q       <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      pulse_seen_q <= pulse_seen_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      valid_q      <= valid_d;
    end
  end

  assign data_rxd   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q == StRecv);

endmodule

// File: tb/tb_irda_receiver.sv
// Directed testbench for irda_receiver with CLKS_PER_BIT=16, even parity.
module tb_irda_receiver;

  localparam int unsigned C = 16;
`ifdef IRDA_RX_GLITCH_FILTER_EN
  localparam int PW  = 6;
  localparam int LAT = 10 * C + 2 + 3;
`else
  localparam int PW  = 3;
  localparam int LAT = 10 * C + 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       rxd_ir;
  logic [6:0] data_rxd;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vtotal = 0;
  int vlast = 0;
  int start_cyc = 0;

  irda_receiver #(
    .CLKS_PER_BIT (C),
    .PARITY_ODD   (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .rxd_ir     (rxd_ir),
    .data_rxd   (data_rxd),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vtotal <= vtotal + 1;
      vlast  <= cyc;
    end
  end

  task automatic idle(input int n);
    rxd_ir = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit window: a PW-wide pulse for 0, nothing for 1.
  task automatic send_bit(input logic b);
    for (int j = 0; j < int'(C); j++) begin
      rxd_ir = (!b && j < PW);
      @(posedge clk);
      #1;
    end
    rxd_ir = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] d, input logic par, input logic stop_pulse);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(!stop_pulse);
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b1; rxd_ir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (data_rxd !== 7'h00) begin n_bad++;
      $display("FAIL reset_data: got %h expected 00", data_rxd); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_valid: got %b expected 0", valid); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_perr: got %b expected 0", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_parity_err;
    int base;
    base = vtotal;
    send_frame(7'h03, 1'b1, 1'b0);  // ^03 = 0, sent 1
    idle(8);
    n_cmp++; if (vtotal - base !== 1) begin n_bad++;
      $display("FAIL perr_valid_count: got %0d expected 1", vtotal - base); end
    n_cmp++; if (data_rxd !== 7'h03) begin n_bad++;
      $display("FAIL perr_data: got %h expected 03", data_rxd); end
    n_cmp++; if (parity_err !== 1'b1) begin n_bad++;
      $display("FAIL perr_flag: got %b expected 1", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++;
      $display("FAIL perr_ferr: got %b expected 0", frame_err); end
  endtask

  task automatic test_frame_err;
    int base;
    base = vtotal;
    send_frame(7'h7F, 1'b1, 1'b1);  // correct parity, pulse in stop window
    idle(8);
    n_cmp++; if (vtotal - base !== 1) begin n_bad++;
      $display("FAIL ferr_valid_count: got %0d expected 1", vtotal - base); end
    n_cmp++; if (data_rxd !== 7'h7F) begin n_bad++;
      $display("FAIL ferr_data: got %h expected 7f", data_rxd); end
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++;
      $display("FAIL ferr_flag: got %b expected 1", frame_err); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++;
      $display("FAIL ferr_perr: got %b expected 0", parity_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL ferr_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_basic;
    int base;
    base = vtotal;
    send_frame(7'h55, 1'b0, 1'b0);
    idle(8);
    n_cmp++; if (vtotal - base !== 1) begin n_bad++;
      $display("FAIL basic_valid_count: got %0d expected 1", vtotal - base); end
    n_cmp++; if (data_rxd !== 7'h55) begin n_bad++;
      $display("FAIL basic_data: got %h expected 55", data_rxd); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++;
      $display("FAIL basic_perr: got %b expected 0", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++;
      $display("FAIL basic_ferr: got %b expected 0", frame_err); end
    n_cmp++; if (vlast - (start_cyc + 1) !== LAT) begin n_bad++;
      $display("FAIL basic_latency: got %0d expected %0d", vlast - (start_cyc + 1), LAT); end
  endtask

  task automatic test_ena_drop;
    int base;
    logic [6:0] d;
    d = 7'h2A;
    base = vtotal;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL ena_busy_mid: got %b expected 1", busy); end
    ena = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL ena_busy_drop: got %b expected 0", busy); end
    // Rest of the frame arrives while disabled and must be ignored.
    for (int i = 5; i < 7; i++) send_bit(d[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(20);
    n_cmp++; if (vtotal - base !== 0) begin n_bad++;
      $display("FAIL ena_no_valid: got %0d expected 0", vtotal - base); end
    n_cmp++; if (data_rxd !== 7'h55) begin n_bad++;
      $display("FAIL ena_data_held: got %h expected 55", data_rxd); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL ena_busy_idle: got %b expected 0", busy); end
    ena = 1'b1;
    idle(4);
  endtask

  task automatic test_reset_mid;
    int base;
    base = vtotal;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_cmp++; if (data_rxd !== 7'h00) begin n_bad++;
      $display("FAIL rstmid_data: got %h expected 00", data_rxd); end
    n_cmp++; if ({valid, parity_err, frame_err} !== 3'b000) begin n_bad++;
      $display("FAIL rstmid_flags: got %b expected 000", {valid, parity_err, frame_err}); end
    idle(3);
    rst = 1'b0;
    idle(5);
    send_frame(7'h11, 1'b0, 1'b0);
    idle(8);
    n_cmp++; if (vtotal - base !== 1) begin n_bad++;
      $display("FAIL rstmid_valid_count: got %0d expected 1", vtotal - base); end
    n_cmp++; if (data_rxd !== 7'h11) begin n_bad++;
      $display("FAIL rstmid_data_after: got %h expected 11", data_rxd); end
    n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_bad++;
      $display("FAIL rstmid_errs_after: got %b expected 00", {parity_err, frame_err}); end
  endtask

`ifdef IRDA_RX_GLITCH_FILTER_EN
  task automatic test_glitch_filter;
    int base;
    base = vtotal;
    rxd_ir = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rxd_ir = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL glitch_busy: got %b expected 0", busy); end
    idle(10);
    send_frame(7'h40, 1'b1, 1'b0);
    idle(10);
    n_cmp++; if (vtotal - base !== 1) begin n_bad++;
      $display("FAIL glitch_valid_count: got %0d expected 1", vtotal - base); end
    n_cmp++; if (data_rxd !== 7'h40) begin n_bad++;
      $display("FAIL glitch_data: got %h expected 40", data_rxd); end
    n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_bad++;
      $display("FAIL glitch_errs: got %b expected 00", {parity_err, frame_err}); end
  endtask
`endif

  initial begin
    test_reset();
    test_parity_err();
    test_frame_err();
    test_basic();
    test_ena_drop();
    test_reset_mid();
`ifdef IRDA_RX_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
